// File: rtl/ndrot_pulse_sequencer.sv
// Command sequencer for a toggle-output NDRO cell: issues toggle-encoded a/b/clk pulses with
// enforced spacing and decodes q toggles into read results with sticky error flags.
module ndrot_pulse_sequencer #(
    parameter int unsigned T_BA     = 5,
    parameter int unsigned T_AB     = 1,
    parameter int unsigned T_CC     = 10,
    parameter int unsigned READ_WIN = 16,
    parameter int unsigned TW       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic       cmd_ready,
    output logic       a_o,
    output logic       b_o,
    output logic       clk_o,
    input  logic       q_i,
    output logic       rd_valid,
    output logic       rd_data,
    output logic       state_o,
    output logic       err_mismatch,
    output logic       err_spurious
);

    typedef enum logic [1:0] {StInit, StIdle, StReadWait} state_e;

    localparam logic [1:0] CmdNop   = 2'd0;
    localparam logic [1:0] CmdSet   = 2'd1;
    localparam logic [1:0] CmdReset = 2'd2;
    localparam logic [1:0] CmdRead  = 2'd3;

    localparam logic [TW-1:0] TBa  = TW'(T_BA);
    localparam logic [TW-1:0] TAb  = TW'(T_AB);
    localparam logic [TW-1:0] TCc  = TW'(T_CC);
    localparam logic [TW-1:0] TWin = TW'(READ_WIN);

    state_e        state_q, state_d;
    // Pulse lines are never reset so that reset can never emit a pulse.
    logic          a_q = 1'b0;
    logic          b_q = 1'b0;
    logic          clk_q = 1'b0;
    logic          a_d, b_d, clk_d;
    logic          q_prev_q, q_edge;
    logic [TW-1:0] tmr_ba_q, tmr_ba_d;
    logic [TW-1:0] tmr_ab_q, tmr_ab_d;
    logic [TW-1:0] tmr_cc_q, tmr_cc_d;
    logic [TW-1:0] win_q, win_d;
    logic          exp_q, exp_d;
    logic          shadow_q, shadow_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_data_q, rd_data_d;
    logic          err_mm_q, err_mm_d;
    logic          err_sp_q, err_sp_d;
    logic          blocked;

    function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    assign q_edge = q_i ^ q_prev_q;

    always_comb begin
        blocked = 1'b0;
        unique case (cmd)
            CmdNop:   blocked = 1'b0;
            CmdSet:   blocked = (tmr_ba_q != '0);
            CmdReset: blocked = (tmr_ab_q != '0);
            CmdRead:  blocked = (tmr_cc_q != '0);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        clk_d      = clk_q;
        tmr_ba_d   = dec_sat(tmr_ba_q);
        tmr_ab_d   = dec_sat(tmr_ab_q);
        tmr_cc_d   = dec_sat(tmr_cc_q);
        win_d      = win_q;
        exp_d      = exp_q;
        shadow_d   = shadow_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        err_mm_d   = err_mm_q;
        err_sp_d   = err_sp_q;
        cmd_ready  = 1'b0;

        case (state_q)
            StInit: begin
                // Force the cell to a known 0 before accepting commands.
                b_d      = ~b_q;
                tmr_ba_d = TBa;
                shadow_d = 1'b0;
                state_d  = StIdle;
                if (q_edge) err_sp_d = 1'b1;
            end
            StIdle: begin
                cmd_ready = ~blocked;
                if (q_edge) err_sp_d = 1'b1;
                if (cmd_valid && !blocked) begin
                    unique case (cmd)
                        CmdNop: begin
                        end
                        CmdSet: begin
                            a_d      = ~a_q;
                            shadow_d = 1'b1;
                            tmr_ab_d = TAb;
                        end
                        CmdReset: begin
                            b_d      = ~b_q;
                            shadow_d = 1'b0;
                            tmr_ba_d = TBa;
                        end
                        CmdRead: begin
                            clk_d    = ~clk_q;
                            tmr_cc_d = TCc;
                            win_d    = TWin;
                            exp_d    = shadow_q;
                            state_d  = StReadWait;
                        end
                    endcase
                end
            end
            StReadWait: begin
                if (q_edge) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = 1'b1;
                    if (!exp_q) err_mm_d = 1'b1;
                    state_d    = StIdle;
                end else if (win_q <= 1) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = 1'b0;
                    if (exp_q) err_mm_d = 1'b1;
                    state_d    = StIdle;
                end else begin
                    win_d = win_q - 1'b1;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk) begin
        q_prev_q <= q_i;
        if (rst) begin
            state_q    <= StInit;
            tmr_ba_q   <= '0;
            tmr_ab_q   <= '0;
            tmr_cc_q   <= '0;
            win_q      <= '0;
            exp_q      <= 1'b0;
            shadow_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 1'b0;
            err_mm_q   <= 1'b0;
            err_sp_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_ba_q   <= tmr_ba_d;
            tmr_ab_q   <= tmr_ab_d;
            tmr_cc_q   <= tmr_cc_d;
            win_q      <= win_d;
            exp_q      <= exp_d;
            shadow_q   <= shadow_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            err_mm_q   <= err_mm_d;
            err_sp_q   <= err_sp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q   <= a_d;
            b_q   <= b_d;
            clk_q <= clk_d;
        end
    end

    assign a_o          = a_q;
    assign b_o          = b_q;
    assign clk_o        = clk_q;
    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign state_o      = shadow_q;
    assign err_mismatch = err_mm_q;
    assign err_spurious = err_sp_q;

endmodule
